mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the CPU's single unified memory port. It shares the port between instruction fetch and the load/store buffer, drives the mem_req/we/sel/addr/data handshake, and holds address stable until read data returns. It also routes each response back to its owner and drops fetch responses invalidated by a pipeline flush. It sits between the fetch unit and LSB on one side and the external RAM interface of tomasulo_cpu on the other.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DATA_STREAK, 4, consecutive LSB grants allowed while fetch waits before fetch is forced (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- if_req_i  in  1  fetch read request
- if_addr_i  in  ADDR_W  fetch address
- if_ready_o  out  1  fetch request accepted this cycle (combinational)
- if_valid_o  out  1  one-cycle pulse, if_data_o valid
- if_data_o  out  DATA_W  fetched word (registered)
- flush_i  in  1  pipeline flush; kills pending/in-flight fetch response
- ls_req_i  in  1  LSB request
- ls_we_i  in  1  1 = store, 0 = load
- ls_addr_i  in  ADDR_W  LSB address
- ls_wdata_i  in  DATA_W  store data
- ls_sel_i  in  4  store byte enables
- ls_ready_o  out  1  LSB request accepted this cycle (combinational)
- ls_valid_o  out  1  one-cycle pulse: load data valid, or store done
- ls_rdata_o  out  DATA_W  load word (registered)
- mem_req_o, mem_we_o  out  1  memory request / write enable (registered)
- mem_addr_o, mem_data_o  out  ADDR_W/DATA_W  memory address / write data (registered)
- mem_sel_o  out  4  byte enables (registered; 4'hF for fetch and loads)
- mem_ready_i  in  1  memory accepts request on this edge
- mem_valid_i  in  1  read data valid on mem_data_i
- mem_data_i  in  DATA_W  read data (combinational from mem_addr_o)

## Operation
- States: IDLE, ISSUE, WAIT. Owner register: FETCH or LSU.
- IDLE grant: only one valid requester → grant it. Both → LSB wins unless the streak counter equals MAX_DATA_STREAK, then fetch. Fetch is never granted in a cycle with flush_i=1.
- Grant: assert that requester's ready_o; latch addr/data/sel/we into mem_*_o; mem_req_o←1; → ISSUE.
- Streak counter: +1 on each LSB grant while if_req_i=1 (saturating at MAX_DATA_STREAK); cleared on a fetch grant or any cycle if_req_i=0.
- ISSUE: hold all mem_*_o. On mem_ready_i=1: mem_req_o←0. Stores → IDLE with ls_valid_o pulse next cycle. Reads → WAIT.
- WAIT: mem_addr_o held (mem_data_i is combinational from it). On mem_valid_i=1: capture mem_data_i into owner's data reg, pulse owner's valid_o, → IDLE.
- Kill flag: set by flush_i while owner=FETCH in ISSUE/WAIT, or on the final WAIT cycle. The memory transaction completes normally; if_valid_o is suppressed and the flag clears on return to IDLE. flush_i has no effect on LSU transactions.
- mem_we_o=0 and mem_sel_o=4'hF for reads; ls_sel_i passed through for stores.
- Reset values: state IDLE, all mem_*_o, valid_o, data_o, streak and kill = 0. Reset mid-transaction abandons it silently; no valid pulse is issued.

## Timing
- Accept in cycle N → mem_req_o high from N+1 until the edge that samples mem_ready_i=1.
- mem_ready_i=1 continuously gives these latencies:
  - Load/fetch: data + valid pulse in cycle N+3, next accept possible in N+3.
  - Store: ls_valid_o in N+2, next accept in N+2.
- mem_ready_i low extends ISSUE one cycle per low cycle. WAIT holds indefinitely until mem_valid_i.
- At most one transaction outstanding. ready_o is never high outside IDLE, and never high for both requesters in the same cycle.
- valid_o pulses are exactly one cycle. data_o holds until the next capture for that requester.

## Test plan
- Single fetch at 0x0000_0100, RAM word 0xDEADBEEF, mem_ready_i=1 → mem_req_o N+1..N+1, if_valid_o and if_data_o=0xDEADBEEF in N+3.
- Store ls_addr 0x3000, wdata 0x12345678, sel 4'b0011 → mem_we_o=1, mem_sel_o=4'b0011 for one cycle, ls_valid_o in N+2; a following load returns 0x00005678 over initial 0.
- if_req and ls_req held high continuously, MAX_DATA_STREAK=4 → grant order LSB,LSB,LSB,LSB,FETCH, repeating; fetch never starved.
- Fetch in WAIT, flush_i pulsed → mem_valid_i still consumed, if_valid_o never asserts, next request serviced normally.
- mem_ready_i held low 5 cycles during ISSUE → mem_addr_o/mem_req_o stable all 5 cycles, response delayed by exactly 5.
- rst low during WAIT → all outputs 0 immediately; after release, fresh load completes with correct data and no spurious valid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch and the load/store buffer.
// Latency: accept in N -> read data + valid pulse in N+3, store done pulse in N+2 (mem_ready_i high).
// Backpressure: ready only in IDLE; mem_ready_i low stretches ISSUE, WAIT holds until mem_valid_i.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              flush_i,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  input  logic [3:0]        ls_sel_i,
  output logic              ls_ready_o,
  output logic              ls_valid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [3:0]        mem_sel_o,
  input  logic              mem_ready_i,
  input  logic              mem_valid_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic {OWN_LSU, OWN_FETCH} owner_t;

  state_t        state;
  state_t        state_nxt;
  owner_t        owner;
  logic          kill;
  logic [SW-1:0] streak;
  logic          streak_full;
  logic          if_live;
  logic          grant_if;
  logic          grant_ls;
  logic          wr_done;
  logic          rd_done;
  logic          deliver_if;
  logic          deliver_ls;

  assign streak_full = (streak == SW'(MAX_DATA_STREAK));

  // Arbitration and next-state: LSB wins ties unless fetch has waited out its streak.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_ls  = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    if_live   = if_req_i & ~flush_i;
    case (state)
      S_IDLE: begin
        if (ls_req_i && !(if_live && streak_full)) begin
          grant_ls = 1'b1;
        end else if (if_live) begin
          grant_if = 1'b1;
        end
        if (grant_ls || grant_if) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ready_i) begin
          if (mem_we_o) begin
            wr_done   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_valid_i) begin
          rd_done   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign if_ready_o = grant_if;
  assign ls_ready_o = grant_ls;

  // A flush landing on the very cycle data returns must still suppress delivery.
  assign deliver_if = rd_done & (owner == OWN_FETCH) & ~kill & ~flush_i;
  assign deliver_ls = rd_done & (owner == OWN_LSU);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Streak of LSB grants taken while fetch was asking; any idle fetch cycle forgives it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (!if_req_i || grant_if) begin
      streak <= '0;
    end else if (grant_ls && !streak_full) begin
      streak <= streak + SW'(1);
    end
  end

  // Owner of the transaction in flight, and whether its fetch response has been flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= OWN_LSU;
      kill  <= 1'b0;
    end else begin
      if (grant_if) begin
        owner <= OWN_FETCH;
      end else if (grant_ls) begin
        owner <= OWN_LSU;
      end
      if (state_nxt == S_IDLE) begin
        kill <= 1'b0;
      end else if (state != S_IDLE && owner == OWN_FETCH && flush_i) begin
        kill <= 1'b1;
      end
    end
  end

  // Memory bus: latched at grant, held through ISSUE; address held through WAIT for the read path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      mem_sel_o  <= 4'h0;
    end else if (grant_ls) begin
      mem_req_o  <= 1'b1;
      mem_we_o   <= ls_we_i;
      mem_addr_o <= ls_addr_i;
      mem_data_o <= ls_we_i ? ls_wdata_i : '0;
      mem_sel_o  <= ls_we_i ? ls_sel_i : 4'hF;
    end else if (grant_if) begin
      mem_req_o  <= 1'b1;
      mem_we_o   <= 1'b0;
      mem_addr_o <= if_addr_i;
      mem_data_o <= '0;
      mem_sel_o  <= 4'hF;
    end else if (state == S_ISSUE && mem_ready_i) begin
      mem_req_o <= 1'b0;
      if (mem_we_o) begin
        mem_we_o  <= 1'b0;
        mem_sel_o <= 4'h0;
      end
    end
  end

  // Response side: one-cycle valid pulses, data registers hold until the owner's next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid_o <= 1'b0;
      ls_valid_o <= 1'b0;
      if_data_o  <= '0;
      ls_rdata_o <= '0;
    end else begin
      if_valid_o <= deliver_if;
      ls_valid_o <= deliver_ls | wr_done;
      if (deliver_if) begin
        if_data_o <= mem_data_i;
      end
      if (deliver_ls) begin
        ls_rdata_o <= mem_data_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM + responder model, directed corner sequences,
// an arbitration vector table and a randomized run against a transaction-level reference.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ready_o, if_valid_o, flush;
  logic [31:0] if_addr, if_data_o;
  logic        ls_req, ls_we, ls_ready_o, ls_valid_o;
  logic [31:0] ls_addr, ls_wdata, ls_rdata_o;
  logic [3:0]  ls_sel;
  logic        mem_req_o, mem_we_o, mem_ready_i, mem_valid_i;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic [3:0]  mem_sel_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready_o),
    .if_valid_o(if_valid_o), .if_data_o(if_data_o), .flush_i(flush),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_sel_i(ls_sel), .ls_ready_o(ls_ready_o), .ls_valid_o(ls_valid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_sel_o(mem_sel_o), .mem_ready_i(mem_ready_i),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i)
  );

  // ---------------- RAM and read responder ----------------
  logic [31:0] ram [0:4095];
  logic        ram_clr, pre_we;
  logic [11:0] pre_idx;
  logic [31:0] pre_dat;
  logic        rd_pend, hold_valid;
  int unsigned dly, resp_delay;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  assign mem_data_i  = ram[mem_addr_o[13:2]];
  assign mem_valid_i = rd_pend && (dly == 0) && !hold_valid;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
    end else if (pre_we) begin
      ram[pre_idx] <= pre_dat;
    end else if (rst && mem_req_o && mem_we_o && mem_ready_i) begin
      ram[mem_addr_o[13:2]] <= merge(ram[mem_addr_o[13:2]], mem_data_o, mem_sel_o);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend <= 1'b0;
      dly     <= 0;
    end else if (rd_pend) begin
      if (mem_valid_i) rd_pend <= 1'b0;
      else if (dly != 0) dly <= dly - 1;
    end else if (mem_req_o && !mem_we_o && mem_ready_i) begin
      rd_pend <= 1'b1;
      dly     <= resp_delay;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] dat);
    pre_we = 1'b1; pre_idx = addr[13:2]; pre_dat = dat;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic do_read(input string nm, input bit fetch, input logic [31:0] addr,
                         input logic [31:0] exp);
    tick();
    if (fetch) begin if_req = 1'b1; if_addr = addr; end
    else begin ls_req = 1'b1; ls_we = 1'b0; ls_addr = addr; end
    @(negedge clk);
    chk({nm, "_ready"}, fetch ? if_ready_o : ls_ready_o, 1);
    tick(); if_req = 1'b0; ls_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk({nm, "_valid"}, fetch ? if_valid_o : ls_valid_o, 1);
    chk({nm, "_data"}, fetch ? if_data_o : ls_rdata_o, exp);
  endtask

  task automatic flushed_fetch(input string nm, input bit on_final);
    int cnt;
    cnt = 0;
    hold_valid = 1'b1;
    tick(); if_req = 1'b1; if_addr = 32'h240;
    @(negedge clk);
    chk({nm, "_ready"}, if_ready_o, 1);
    tick(); if_req = 1'b0;
    tick(); flush = !on_final;
    tick(); flush = on_final; hold_valid = 1'b0;
    tick(); flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      if (if_valid_o) cnt++;
    end
    chk({nm, "_no_if_valid"}, cnt, 0);
  endtask

  typedef struct {
    logic if_req, ls_req, flush, exp_if, exp_ls;
  } arb_vec_t;

  arb_vec_t vecs [7];

  // ---------------- reference model state for the random run ----------------
  logic [31:0] ref_ram [0:63];
  bit          busy, cur_fetch, cur_store, killed, if_acc, ls_acc;
  bit          exp_ifv, exp_lsv, exp_ls_load, e_if, e_ls, fe;
  logic [31:0] cur_exp, exp_ifd, exp_lsd;
  int          streak_m, deliveries;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b0; if_req = 0; if_addr = 0; flush = 0; ls_req = 0; ls_we = 0;
    ls_addr = 0; ls_wdata = 0; ls_sel = 0; mem_ready_i = 1'b1;
    ram_clr = 1'b1; pre_we = 1'b0; pre_idx = 0; pre_dat = 0;
    hold_valid = 1'b0; resp_delay = 0;
    tick(); tick(); ram_clr = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_mem_sel", mem_sel_o, 0);
    chk("rst_if_valid", if_valid_o, 0);
    chk("rst_ls_valid", ls_valid_o, 0);
    chk("rst_if_data", if_data_o, 0);
    chk("rst_ls_rdata", ls_rdata_o, 0);
    tick(); rst = 1'b1;
    tick();

    // Arbitration table: requests withdrawn before the edge, so nothing is actually granted.
    foreach (vecs[i]) begin
      tick();
      if_req = vecs[i].if_req; ls_req = vecs[i].ls_req; flush = vecs[i].flush;
      #2;
      chk($sformatf("vec%0d_if_ready", i), if_ready_o, vecs[i].exp_if);
      chk($sformatf("vec%0d_ls_ready", i), ls_ready_o, vecs[i].exp_ls);
      #1;
      if_req = 1'b0; ls_req = 1'b0; flush = 1'b0;
    end

    // Single fetch.
    preload(32'h100, 32'hDEADBEEF);
    tick(); if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("t1_if_ready", if_ready_o, 1);
    chk("t1_ls_ready", ls_ready_o, 0);
    tick(); if_req = 1'b0;
    @(negedge clk);
    chk("t1_req_n1", mem_req_o, 1);
    chk("t1_addr_n1", mem_addr_o, 32'h100);
    chk("t1_sel_n1", mem_sel_o, 4'hF);
    chk("t1_we_n1", mem_we_o, 0);
    tick();
    @(negedge clk);
    chk("t1_req_n2", mem_req_o, 0);
    chk("t1_valid_n2", if_valid_o, 0);
    tick();
    @(negedge clk);
    chk("t1_valid_n3", if_valid_o, 1);
    chk("t1_data_n3", if_data_o, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("t1_valid_n4", if_valid_o, 0);
    chk("t1_data_hold", if_data_o, 32'hDEADBEEF);

    // Partial store, then a back-to-back load of the same word.
    tick(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h3000; ls_wdata = 32'h12345678; ls_sel = 4'b0011;
    @(negedge clk);
    chk("t2_ls_ready", ls_ready_o, 1);
    tick(); ls_req = 1'b0;
    @(negedge clk);
    chk("t2_req", mem_req_o, 1);
    chk("t2_we", mem_we_o, 1);
    chk("t2_sel", mem_sel_o, 4'b0011);
    chk("t2_wdata", mem_data_o, 32'h12345678);
    chk("t2_valid_n1", ls_valid_o, 0);
    tick(); ls_req = 1'b1; ls_we = 1'b0;
    @(negedge clk);
    chk("t2_valid_n2", ls_valid_o, 1);
    chk("t2_we_cleared", mem_we_o, 0);
    chk("t2_load_ready_n2", ls_ready_o, 1);
    tick(); ls_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("t2_load_valid", ls_valid_o, 1);
    chk("t2_load_data", ls_rdata_o, 32'h00005678);

    // Both requesters held: four LSB grants then one fetch, repeating.
    begin
      int g [10];
      int n;
      n = 0;
      foreach (g[i]) g[i] = 2;
      tick(); if_req = 1'b1; if_addr = 32'h200; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400;
      for (int c = 0; c < 300 && n < 10; c++) begin
        if (c > 0) tick();
        @(negedge clk);
        if (if_ready_o) begin g[n] = 1; n++; end
        else if (ls_ready_o) begin g[n] = 0; n++; end
      end
      tick(); if_req = 1'b0; ls_req = 1'b0;
      chk("t3_grant_count", n, 10);
      for (int i = 0; i < 10; i++) chk($sformatf("t3_grant%0d", i), g[i], (i % 5 == 4) ? 1 : 0);
      for (int i = 0; i < 5; i++) tick();
    end

    // Flushed fetches: flush while waiting, and flush on the data-return cycle.
    preload(32'h240, 32'hCAFEF00D);
    flushed_fetch("t4_mid", 1'b0);
    flushed_fetch("t4_final", 1'b1);
    do_read("t4_after", 1'b1, 32'h240, 32'hCAFEF00D);

    // mem_ready_i low for five ISSUE cycles.
    begin
      bit stable;
      stable = 1'b1;
      preload(32'h280, 32'h0BADC0DE);
      tick(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h280;
      @(negedge clk);
      chk("t5_ready", ls_ready_o, 1);
      tick(); ls_req = 1'b0; mem_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) tick();
        @(negedge clk);
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h280 || ls_valid_o !== 1'b0) stable = 1'b0;
      end
      chk("t5_stable", stable, 1);
      tick(); mem_ready_i = 1'b1;
      tick();
      @(negedge clk);
      chk("t5_not_early", ls_valid_o, 0);
      tick();
      @(negedge clk);
      chk("t5_valid_n8", ls_valid_o, 1);
      chk("t5_data", ls_rdata_o, 32'h0BADC0DE);
    end

    // Reset during WAIT.
    begin
      int cnt;
      cnt = 0;
      preload(32'h300, 32'h13572468);
      hold_valid = 1'b1;
      tick(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2C0;
      tick(); ls_req = 1'b0;
      tick();
      #1 rst = 1'b0;
      #1;
      chk("t6_rst_req", mem_req_o, 0);
      chk("t6_rst_addr", mem_addr_o, 0);
      chk("t6_rst_sel", mem_sel_o, 0);
      chk("t6_rst_ls_rdata", ls_rdata_o, 0);
      chk("t6_rst_if_data", if_data_o, 0);
      hold_valid = 1'b0;
      tick(); tick(); rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        @(negedge clk);
        if (ls_valid_o || if_valid_o) cnt++;
      end
      chk("t6_no_spurious", cnt, 0);
      do_read("t6_fresh", 1'b0, 32'h300, 32'h13572468);
    end

    // Randomized traffic against the transaction-level reference.
    for (int i = 0; i < 5; i++) tick();
    ram_clr = 1'b1;
    tick();
    ram_clr = 1'b0;
    foreach (ref_ram[i]) ref_ram[i] = '0;
    busy = 0; killed = 0; cur_fetch = 0; cur_store = 0; if_acc = 0; ls_acc = 0;
    exp_ifv = 0; exp_lsv = 0; exp_ls_load = 0; streak_m = 0; deliveries = 0;
    cur_exp = 0; exp_ifd = 0; exp_lsd = 0;
    for (int cyc = 0; cyc < 3040; cyc++) begin
      tick();
      if (cyc < 3000) begin
        if (!if_req || if_acc) begin
          if_req  = ($urandom_range(0, 2) != 0);
          if_addr = 32'($urandom_range(0, 63)) << 2;
        end
        if (!ls_req || ls_acc) begin
          ls_req   = ($urandom_range(0, 2) != 0);
          ls_we    = ($urandom_range(0, 1) != 0);
          ls_addr  = 32'($urandom_range(0, 63)) << 2;
          ls_wdata = $urandom;
          ls_sel   = 4'($urandom_range(0, 15));
        end
        flush       = ($urandom_range(0, 7) == 0);
        mem_ready_i = ($urandom_range(0, 3) != 0);
        resp_delay  = $urandom_range(0, 3);
      end else begin
        if_req = 1'b0; ls_req = 1'b0; flush = 1'b0; mem_ready_i = 1'b1; resp_delay = 0;
      end
      @(negedge clk);

      chk("rnd_if_valid", if_valid_o, exp_ifv);
      if (exp_ifv) chk("rnd_if_data", if_data_o, exp_ifd);
      chk("rnd_ls_valid", ls_valid_o, exp_lsv);
      if (exp_lsv && exp_ls_load) chk("rnd_ls_data", ls_rdata_o, exp_lsd);

      e_if = 0; e_ls = 0;
      if (!busy) begin
        fe   = if_req && !flush;
        e_ls = ls_req && !(fe && streak_m == MAXS);
        e_if = fe && !e_ls;
      end
      chk("rnd_if_ready", if_ready_o, e_if);
      chk("rnd_ls_ready", ls_ready_o, e_ls);

      exp_ifv = 0; exp_lsv = 0; exp_ls_load = 0; if_acc = 0; ls_acc = 0;
      if (busy) begin
        if (cur_fetch && flush) killed = 1;
        if (cur_store) begin
          if (mem_req_o && mem_we_o && mem_ready_i) begin
            exp_lsv = 1; busy = 0; deliveries++;
          end
        end else if (mem_valid_i) begin
          busy = 0; deliveries++;
          if (cur_fetch) begin
            if (!killed) begin exp_ifv = 1; exp_ifd = cur_exp; end
          end else begin
            exp_lsv = 1; exp_ls_load = 1; exp_lsd = cur_exp;
          end
        end
      end else if (e_if || e_ls) begin
        busy = 1; killed = 0; cur_fetch = e_if; cur_store = e_ls && ls_we;
        if_acc = e_if; ls_acc = e_ls;
        if (e_if) cur_exp = ref_ram[if_addr[7:2]];
        else if (ls_we) ref_ram[ls_addr[7:2]] = merge(ref_ram[ls_addr[7:2]], ls_wdata, ls_sel);
        else cur_exp = ref_ram[ls_addr[7:2]];
      end
      if (!if_req || e_if) streak_m = 0;
      else if (e_ls && streak_m < MAXS) streak_m++;
    end
    chk("rnd_drained", busy, 0);
    chk("rnd_activity", deliveries > 200, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
